// File: rtl/mshr_table.sv
`default_nettype none
// ============================================================================
// Module      : mshr_table
// Description : Miss status holding register table for one cache bank.
// Revision    : 1.0 - initial release
// ============================================================================
module mshr_table #(
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 2,
  parameter int LINE_LO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             dealloc,
  input  logic [14:0]      pAddress,
  input  logic [6:0]       ptcid_in,
  input  logic             rdsw_in,
  output logic             mshr_hit,
  output logic             mshr_full,
  output logic [IDX_W:0]   count,
  output logic             wake_valid,
  output logic [6:0]       wake_ptcid,
  output logic             wake_rdsw,
  output logic [14:0]      wake_pAddress,
  output logic             err_overflow,
  output logic             err_orphan
);

  localparam int             c_tag_w    = 15 - LINE_LO;
  localparam logic [IDX_W:0] c_full_cnt = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]   r_valid;
  logic [c_tag_w-1:0] r_tag   [DEPTH];
  logic [6:0]         r_ptcid [DEPTH];
  logic               r_rdsw  [DEPTH];
  logic [IDX_W:0]     r_count;
  logic               r_full;
  logic               r_wake_valid;
  logic [6:0]         r_wake_ptcid;
  logic               r_wake_rdsw;
  logic [c_tag_w-1:0] r_wake_tag;
  logic               r_err_ov;
  logic               r_err_or;

  logic [c_tag_w-1:0] w_tag;
  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_alloc_ok;
  logic               w_free;
  logic [IDX_W:0]     w_count_next;
  logic               w_unused;

  assign w_tag    = pAddress[14:LINE_LO];
  // Byte offset within the line never takes part in matching.
  assign w_unused = ^pAddress[LINE_LO-1:0];

  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_tag[i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
    // Descending scan leaves the lowest invalid index.
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign w_alloc_ok   = alloc & ~r_full & ~w_hit;
  assign w_free       = dealloc & w_hit;
  assign w_count_next = r_count + (IDX_W+1)'(w_alloc_ok) - (IDX_W+1)'(w_free);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]   <= '0;
        r_ptcid[i] <= '0;
        r_rdsw[i]  <= 1'b0;
      end
      r_count      <= '0;
      r_full       <= 1'b0;
      r_wake_valid <= 1'b0;
      r_wake_ptcid <= '0;
      r_wake_rdsw  <= 1'b0;
      r_wake_tag   <= '0;
      r_err_ov     <= 1'b0;
      r_err_or     <= 1'b0;
    end else begin
      // Accepted alloc implies no hit, so it never targets the entry being freed.
      if (w_alloc_ok) begin
        r_valid[w_free_idx] <= 1'b1;
        r_tag[w_free_idx]   <= w_tag;
        r_ptcid[w_free_idx] <= ptcid_in;
        r_rdsw[w_free_idx]  <= rdsw_in;
      end
      if (w_free) begin
        r_valid[w_hit_idx] <= 1'b0;
        r_wake_ptcid       <= r_ptcid[w_hit_idx];
        r_wake_rdsw        <= r_rdsw[w_hit_idx];
        r_wake_tag         <= r_tag[w_hit_idx];
      end
      r_wake_valid <= w_free;
      r_count      <= w_count_next;
      r_full       <= (w_count_next == c_full_cnt);
      if (alloc && r_full) r_err_ov <= 1'b1;
      if (dealloc && !w_hit) r_err_or <= 1'b1;
    end
  end

  assign mshr_hit      = w_hit;
  assign mshr_full     = r_full;
  assign count         = r_count;
  assign wake_valid    = r_wake_valid;
  assign wake_ptcid    = r_wake_ptcid;
  assign wake_rdsw     = r_wake_rdsw;
  assign wake_pAddress = {r_wake_tag, {LINE_LO{1'b0}}};
  assign err_overflow  = r_err_ov;
  assign err_orphan    = r_err_or;

endmodule
`default_nettype wire

// File: tb/tb_mshr_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_mshr_table
// Description : Self-checking bench for mshr_table (vector table + random model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mshr_table;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc = 1'b0, dealloc = 1'b0;
  logic [14:0] pAddress = '0;
  logic [6:0]  ptcid_in = '0;
  logic        rdsw_in = 1'b0;
  logic        mshr_hit, mshr_full, wake_valid, wake_rdsw, err_overflow, err_orphan;
  logic [2:0]  count;
  logic [6:0]  wake_ptcid;
  logic [14:0] wake_pAddress;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mshr_table #(.DEPTH(4), .IDX_W(2), .LINE_LO(4)) dut (
    .clk(clk), .rst(rst), .alloc(alloc), .dealloc(dealloc), .pAddress(pAddress),
    .ptcid_in(ptcid_in), .rdsw_in(rdsw_in), .mshr_hit(mshr_hit), .mshr_full(mshr_full),
    .count(count), .wake_valid(wake_valid), .wake_ptcid(wake_ptcid), .wake_rdsw(wake_rdsw),
    .wake_pAddress(wake_pAddress), .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  typedef struct packed {
    logic a; logic d; logic [14:0] pa; logic [6:0] pt; logic rd;
    logic hit; logic [2:0] cnt; logic full; logic wv; logic ov; logic orph;
    logic [6:0] wpt; logic wrd; logic [14:0] wpa;
  } vec_t;

  typedef struct { logic [10:0] line; logic [6:0] ptc; logic rd; } ent_t;

  vec_t tbl [16];
  ent_t m_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a, input logic d, input logic [14:0] pa,
                       input logic [6:0] pt, input logic rd);
    @(negedge clk);
    alloc = a; dealloc = d; pAddress = pa; ptcid_in = pt; rdsw_in = rd;
    #1;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; alloc = 1'b0; dealloc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //          a  d  pa       pt     rd hit cnt full wv ov or  wpt    wrd wpa
    tbl[0]  = '{1'b1,1'b0,15'h0120,7'h05,1'b0, 1'b0,3'd1,1'b0,1'b0,1'b0,1'b0, 7'h00,1'b0,15'h0000};
    tbl[1]  = '{1'b0,1'b0,15'h012F,7'h00,1'b0, 1'b1,3'd1,1'b0,1'b0,1'b0,1'b0, 7'h00,1'b0,15'h0000};
    tbl[2]  = '{1'b0,1'b0,15'h0130,7'h00,1'b0, 1'b0,3'd1,1'b0,1'b0,1'b0,1'b0, 7'h00,1'b0,15'h0000};
    tbl[3]  = '{1'b0,1'b1,15'h0120,7'h00,1'b0, 1'b1,3'd0,1'b0,1'b1,1'b0,1'b0, 7'h05,1'b0,15'h0120};
    tbl[4]  = '{1'b1,1'b0,15'h0000,7'h01,1'b0, 1'b0,3'd1,1'b0,1'b0,1'b0,1'b0, 7'h05,1'b0,15'h0120};
    tbl[5]  = '{1'b1,1'b0,15'h0010,7'h02,1'b0, 1'b0,3'd2,1'b0,1'b0,1'b0,1'b0, 7'h05,1'b0,15'h0120};
    tbl[6]  = '{1'b1,1'b0,15'h0020,7'h2A,1'b1, 1'b0,3'd3,1'b0,1'b0,1'b0,1'b0, 7'h05,1'b0,15'h0120};
    tbl[7]  = '{1'b1,1'b0,15'h0030,7'h04,1'b0, 1'b0,3'd4,1'b1,1'b0,1'b0,1'b0, 7'h05,1'b0,15'h0120};
    tbl[8]  = '{1'b1,1'b0,15'h0040,7'h06,1'b0, 1'b0,3'd4,1'b1,1'b0,1'b1,1'b0, 7'h05,1'b0,15'h0120};
    tbl[9]  = '{1'b0,1'b1,15'h0020,7'h00,1'b0, 1'b1,3'd3,1'b0,1'b1,1'b1,1'b0, 7'h2A,1'b1,15'h0020};
    tbl[10] = '{1'b0,1'b0,15'h0020,7'h00,1'b0, 1'b0,3'd3,1'b0,1'b0,1'b1,1'b0, 7'h2A,1'b1,15'h0020};
    tbl[11] = '{1'b0,1'b1,15'h0500,7'h00,1'b0, 1'b0,3'd3,1'b0,1'b0,1'b1,1'b1, 7'h2A,1'b1,15'h0020};
    tbl[12] = '{1'b1,1'b1,15'h0010,7'h33,1'b0, 1'b1,3'd2,1'b0,1'b1,1'b1,1'b1, 7'h02,1'b0,15'h0010};
    tbl[13] = '{1'b1,1'b0,15'h001C,7'h11,1'b0, 1'b0,3'd3,1'b0,1'b0,1'b1,1'b1, 7'h02,1'b0,15'h0010};
    tbl[14] = '{1'b1,1'b0,15'h0050,7'h44,1'b0, 1'b0,3'd4,1'b1,1'b0,1'b1,1'b1, 7'h02,1'b0,15'h0010};
    tbl[15] = '{1'b1,1'b1,15'h0057,7'h55,1'b1, 1'b1,3'd3,1'b0,1'b1,1'b1,1'b1, 7'h44,1'b0,15'h0050};

    // Reset state
    #2;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_full", 32'(mshr_full), 32'd0);
    chk("reset_hit", 32'(mshr_hit), 32'd0);
    chk("reset_wake", 32'(wake_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int v = 0; v < 16; v++) begin
      drive(tbl[v].a, tbl[v].d, tbl[v].pa, tbl[v].pt, tbl[v].rd);
      chk($sformatf("vec%0d_hit", v), 32'(mshr_hit), 32'(tbl[v].hit));
      post_edge();
      chk($sformatf("vec%0d_count", v), 32'(count), 32'(tbl[v].cnt));
      chk($sformatf("vec%0d_full", v), 32'(mshr_full), 32'(tbl[v].full));
      chk($sformatf("vec%0d_wake_valid", v), 32'(wake_valid), 32'(tbl[v].wv));
      chk($sformatf("vec%0d_err_ov", v), 32'(err_overflow), 32'(tbl[v].ov));
      chk($sformatf("vec%0d_err_or", v), 32'(err_orphan), 32'(tbl[v].orph));
      chk($sformatf("vec%0d_wake_ptcid", v), 32'(wake_ptcid), 32'(tbl[v].wpt));
      chk($sformatf("vec%0d_wake_rdsw", v), 32'(wake_rdsw), 32'(tbl[v].wrd));
      chk($sformatf("vec%0d_wake_addr", v), 32'(wake_pAddress), 32'(tbl[v].wpa));
    end

    // Asynchronous reset mid-cycle with three pending entries
    drive(1'b0, 1'b0, 15'h0008, 7'h00, 1'b0);
    chk("pre_rst_hit", 32'(mshr_hit), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_full", 32'(mshr_full), 32'd0);
    chk("async_rst_hit", 32'(mshr_hit), 32'd0);
    chk("async_rst_ov", 32'(err_overflow), 32'd0);
    chk("async_rst_or", 32'(err_orphan), 32'd0);
    chk("async_rst_waddr", 32'(wake_pAddress), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full table: alloc+dealloc on a pending line drops alloc and flags overflow
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 15'(15'h0100 + 15'(k * 16)), 7'(k + 8), 1'b0);
      post_edge();
    end
    chk("fill_full", 32'(mshr_full), 32'd1);
    chk("fill_ov_clear", 32'(err_overflow), 32'd0);
    drive(1'b1, 1'b1, 15'h0113, 7'h7F, 1'b1);
    chk("full_ad_hit", 32'(mshr_hit), 32'd1);
    post_edge();
    chk("full_ad_count", 32'(count), 32'd3);
    chk("full_ad_ov", 32'(err_overflow), 32'd1);
    chk("full_ad_wake", 32'(wake_valid), 32'd1);
    chk("full_ad_wptc", 32'(wake_ptcid), 32'h09);
    drive(1'b0, 1'b0, 15'h0000, 7'h00, 1'b0);
    post_edge();
    chk("pulse_end", 32'(wake_valid), 32'd0);

    // Randomised traffic against a queue-based reference model
    do_reset();
    begin
      logic       m_ov, m_or, m_wv, m_wrd;
      logic [6:0] m_wpt;
      logic [14:0] m_wpa;
      m_q.delete();
      m_ov = 0; m_or = 0; m_wv = 0; m_wrd = 0; m_wpt = '0; m_wpa = '0;
      for (int c = 0; c < 800; c++) begin
        logic a, d, rd, hit, full_pre;
        logic [14:0] pa;
        logic [6:0]  pt;
        int idx;
        a  = ($urandom % 2) == 1;
        d  = ($urandom % 5) < 2;
        pa = 15'((($urandom % 6) << 4) | ($urandom % 16));
        if (($urandom % 16) == 0) pa = 15'($urandom);
        pt = 7'($urandom);
        rd = 1'($urandom);
        drive(a, d, pa, pt, rd);
        idx = -1;
        foreach (m_q[j]) if (m_q[j].line == pa[14:4]) idx = j;
        hit = (idx >= 0);
        full_pre = (m_q.size() == 4);
        chk("rnd_hit", 32'(mshr_hit), 32'(hit));
        if (a && full_pre) m_ov = 1;
        if (d && !hit) m_or = 1;
        m_wv = d && hit;
        if (m_wv) begin
          m_wpt = m_q[idx].ptc;
          m_wrd = m_q[idx].rd;
          m_wpa = {pa[14:4], 4'b0000};
          m_q.delete(idx);
        end
        if (a && !full_pre && !hit) m_q.push_back('{pa[14:4], pt, rd});
        post_edge();
        chk("rnd_count", 32'(count), 32'(m_q.size()));
        chk("rnd_full", 32'(mshr_full), 32'(m_q.size() == 4));
        chk("rnd_wake_valid", 32'(wake_valid), 32'(m_wv));
        chk("rnd_wake_ptcid", 32'(wake_ptcid), 32'(m_wpt));
        chk("rnd_wake_rdsw", 32'(wake_rdsw), 32'(m_wrd));
        chk("rnd_wake_addr", 32'(wake_pAddress), 32'(m_wpa));
        chk("rnd_err_ov", 32'(err_overflow), 32'(m_ov));
        chk("rnd_err_or", 32'(err_orphan), 32'(m_or));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
